// File: rtl/store_port_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_port_responder_pkg : D$ store-port types and write-queue entry types
// Rev 1.0
// ---------------------------------------------------------------------------
package store_port_responder_pkg;

  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH   = 44;
  localparam int ADDR_WIDTH         = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
  localparam int WORD_ADDR_WIDTH    = ADDR_WIDTH - 3;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
    logic                          approx;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef struct packed {
    logic [WORD_ADDR_WIDTH-1:0] word_addr;
    logic [63:0]                data;
    logic [7:0]                 be;
    logic                       approx;
    logic                       valid;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } wbuf_state_e;

  // 64-bit word index of a {tag,index} byte address
  function automatic logic [WORD_ADDR_WIDTH-1:0] word_addr_of(
    input logic [DCACHE_TAG_WIDTH-1:0]   tag,
    input logic [DCACHE_INDEX_WIDTH-1:0] idx
  );
    logic [ADDR_WIDTH-1:0] full;
    full = {tag, idx};
    return full[ADDR_WIDTH-1:3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_port_responder_merge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wbuf_merge_unit : byte-enable merge of new data over old, optional LSB clear
// Rev 1.0
// ---------------------------------------------------------------------------
module wbuf_merge_unit #(
  parameter int APPROX_LSB = 8
) (
  input  logic [63:0] old_data_i,
  input  logic [63:0] new_data_i,
  input  logic [7:0]  be_i,
  input  logic        approx_i,
  output logic [63:0] data_o
);

  localparam logic [63:0] KEEP_MASK = ~((64'd1 << APPROX_LSB) - 64'd1);

  logic [63:0] w_merged;

  for (genvar b = 0; b < 8; b++) begin : g_byte
    assign w_merged[8*b +: 8] = be_i[b] ? new_data_i[8*b +: 8] : old_data_i[8*b +: 8];
  end

  assign data_o = approx_i ? (w_merged & KEEP_MASK) : w_merged;

endmodule
`default_nettype wire

// File: rtl/store_port_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_port_responder : coalescing D$ write queue draining to a word memory
// Rev 1.0
// ---------------------------------------------------------------------------
module store_port_responder
  import store_port_responder_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int APPROX_LSB = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  dcache_req_i_t req_port_i,
  output dcache_req_o_t req_port_o,
  output logic          mem_req_o,
  input  logic          mem_gnt_i,
  input  logic          mem_ack_i,
  output logic [63:0]   mem_addr_o,
  output logic [63:0]   mem_wdata_o,
  output logic [7:0]    mem_be_o,
  output logic          idle_o
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WBUF_DEPTH);

  wbuf_entry_t                entries_q [WBUF_DEPTH];
  wbuf_entry_t                entries_d [WBUF_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  wbuf_state_e                state_q, state_d;
  logic                       rvalid_q;

  logic [PTR_W-1:0]           w_tail_idx;
  wbuf_entry_t                w_tail;
  logic [WORD_ADDR_WIDTH-1:0] w_word;
  logic                       w_acc, w_merge, w_gnt, w_alloc, w_pop, w_issue;
  logic [63:0]                w_merge_data, w_issue_data;
  logic                       w_unused_bits;

  assign w_unused_bits = ^{req_port_i.tag_valid, req_port_i.data_size};

  assign w_word     = word_addr_of(req_port_i.address_tag, req_port_i.address_index);
  assign w_tail_idx = wr_ptr_q - 1'b1;
  assign w_tail     = entries_q[w_tail_idx];

  assign w_acc = req_port_i.data_req & req_port_i.data_we & ~req_port_i.kill_req;

  // The head is frozen once the drain FSM has picked it up
  assign w_merge = (count_q != '0) & w_tail.valid
                 & ~((state_q != IDLE) & (w_tail_idx == rd_ptr_q))
                 & (w_tail.word_addr == w_word)
                 & (w_tail.approx == req_port_i.approx);

  assign w_gnt   = w_acc & (w_merge | (count_q < DEPTH_C));
  assign w_alloc = w_gnt & ~w_merge;
  assign w_pop   = (state_q == WAIT) & mem_ack_i;

  wbuf_merge_unit #(.APPROX_LSB(APPROX_LSB)) u_merge (
    .old_data_i (w_tail.data),
    .new_data_i (req_port_i.data_wdata),
    .be_i       (req_port_i.data_be),
    .approx_i   (1'b0),
    .data_o     (w_merge_data)
  );

  wbuf_merge_unit #(.APPROX_LSB(APPROX_LSB)) u_issue (
    .old_data_i (entries_q[rd_ptr_q].data),
    .new_data_i (64'd0),
    .be_i       (8'd0),
    .approx_i   (entries_q[rd_ptr_q].approx),
    .data_o     (w_issue_data)
  );

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (w_gnt && w_merge) begin
      entries_d[w_tail_idx].data = w_merge_data;
      entries_d[w_tail_idx].be   = w_tail.be | req_port_i.data_be;
    end
    if (w_alloc) begin
      entries_d[wr_ptr_q] = '{word_addr: w_word,
                              data:      req_port_i.data_wdata,
                              be:        req_port_i.data_be,
                              approx:    req_port_i.approx,
                              valid:     1'b1};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      entries_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (rst_i) begin
      for (int i = 0; i < WBUF_DEPTH; i++) entries_d[i].valid = 1'b0;
    end
    count_d = count_q + CNT_W'(w_alloc) - CNT_W'(w_pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = ISSUE;
      ISSUE:   if (mem_gnt_i) state_d = WAIT;
      WAIT:    if (mem_ack_i) state_d = (count_d != '0) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    entries_q <= entries_d;
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rvalid_q <= w_gnt;
    end
  end

  assign w_issue     = (state_q == ISSUE);
  assign mem_req_o   = w_issue;
  assign mem_addr_o  = w_issue ? 64'({entries_q[rd_ptr_q].word_addr, 3'b000}) : 64'd0;
  assign mem_wdata_o = w_issue ? w_issue_data : 64'd0;
  assign mem_be_o    = w_issue ? entries_q[rd_ptr_q].be : 8'd0;
  assign idle_o      = (count_q == '0) & (state_q == IDLE);

  assign req_port_o = '{data_gnt: w_gnt, data_rvalid: rvalid_q, data_rdata: 64'd0};

endmodule
`default_nettype wire

// File: tb/tb_store_port_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_store_port_responder : store vectors with a scoreboard on memory writes
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_store_port_responder;
  import store_port_responder_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_i;
  dcache_req_i_t req_port_i;
  dcache_req_o_t req_port_o;
  logic          mem_req_o, mem_gnt_i, mem_ack_i;
  logic [63:0]   mem_addr_o, mem_wdata_o;
  logic [7:0]    mem_be_o;
  logic          idle_o;

  store_port_responder #(.WBUF_DEPTH(4), .APPROX_LSB(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_port_i  (req_port_i),
    .req_port_o  (req_port_o),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_ack_i   (mem_ack_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .idle_o      (idle_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    bit          approx;
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
    logic [7:0]  exp_be;
  } vec_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  bit  mem_en = 1'b0;
  bit  gnt_only = 1'b0;
  bit  late_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Backing-memory model: grants at once, acks two cycles later
  initial begin
    int  ack_cnt;
    wr_t e;
    ack_cnt   = 0;
    mem_gnt_i = 1'b0;
    mem_ack_i = 1'b0;
    forever begin
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      mem_ack_i = late_ack;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) mem_ack_i = 1'b1;
      end else if (mem_en && mem_req_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr_o, mem_wdata_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr_o, e.addr);
          check("wr_data", mem_wdata_o, e.data);
          check("wr_be", 64'(mem_be_o), 64'(e.be));
        end
        mem_gnt_i = 1'b1;
        ack_cnt   = gnt_only ? 0 : 2;
      end
    end
  end

  // Called and returning 1 time unit after a rising edge
  task automatic do_store(input logic [63:0] addr, input logic [63:0] d, input logic [7:0] be,
                          input bit ap, input int max_wait, output bit granted);
    req_port_i.address_index = addr[11:0];
    req_port_i.address_tag   = addr[55:12];
    req_port_i.data_wdata    = d;
    req_port_i.data_be       = be;
    req_port_i.approx        = ap;
    req_port_i.data_req      = 1'b1;
    req_port_i.data_we       = 1'b1;
    req_port_i.kill_req      = 1'b0;
    granted = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (req_port_o.data_gnt) begin
        granted = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (granted) begin
      @(posedge clk_i); #1;
      req_port_i.data_req = 1'b0;
      check("rvalid_after_gnt", 64'(req_port_o.data_rvalid), 64'd1);
      check("rdata_zero", req_port_o.data_rdata, 64'd0);
    end else begin
      req_port_i.data_req = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk_i);
      if (idle_o && exp_q.size() == 0) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: idle_o=%0b pending=%0d, required idle_o=1 pending=0", name, idle_o, exp_q.size());
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    bit   g;

    vecs[0] = '{64'h7000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 64'h7000, 64'hFFFF_FFFF_FFFF_FF00, 8'hFF};
    vecs[1] = '{64'h7008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 64'h7008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF};
    vecs[2] = '{64'h7013, 64'h0123_4567_89AB_CDEF, 8'h3C, 1'b0, 64'h7010, 64'h0123_4567_89AB_CDEF, 8'h3C};
    vecs[3] = '{64'hABCD_EF12_3458, 64'hDEAD_BEEF_CAFE_F00D, 8'h01, 1'b1,
                64'hABCD_EF12_3458, 64'hDEAD_BEEF_CAFE_F000, 8'h01};
    vecs[4] = '{64'h00FF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 8'h80, 1'b0,
                64'h00FF_FFFF_FFFF_FFF8, 64'h8000_0000_0000_0001, 8'h80};
    vecs[5] = '{64'h7100, 64'h55AA_55AA_55AA_55AA, 8'hFF, 1'b0, 64'h7100, 64'h55AA_55AA_55AA_55AA, 8'hFF};
    vecs[6] = '{64'h7100, 64'h55AA_55AA_55AA_55AA, 8'hFF, 1'b1, 64'h7100, 64'h55AA_55AA_55AA_5500, 8'hFF};

    req_port_i = '0;
    rst_i      = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_mem_addr", mem_addr_o, 64'd0);
    check("rst_mem_wdata", mem_wdata_o, 64'd0);
    check("rst_mem_be", 64'(mem_be_o), 64'd0);
    check("rst_rvalid", 64'(req_port_o.data_rvalid), 64'd0);
    rst_i = 1'b0;

    // Loads and killed stores are never granted
    req_port_i.data_req = 1'b1;
    req_port_i.data_we  = 1'b0;
    #1 check("load_no_gnt", 64'(req_port_o.data_gnt), 64'd0);
    req_port_i.data_we  = 1'b1;
    req_port_i.kill_req = 1'b1;
    #1 check("kill_no_gnt", 64'(req_port_o.data_gnt), 64'd0);
    req_port_i = '0;
    @(posedge clk_i); #1;
    check("no_rvalid_without_gnt", 64'(req_port_o.data_rvalid), 64'd0);
    check("idle_after_rejects", 64'(idle_o), 64'd1);

    // Single store
    mem_en = 1'b1;
    exp_q.push_back('{64'h1008, 64'h1122_3344_5566_7788, 8'hFF});
    do_store(64'h1008, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 1, g);
    check("single_gnt_same_cycle", 64'(g), 64'd1);
    wait_idle("single_drain", 40);

    // Table vectors, back to back while draining
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_be});
      do_store(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].approx, 30, g);
      check("vec_gnt", 64'(g), 64'd1);
    end
    wait_idle("vec_drain", 100);

    // Coalesce into the tail before the drain FSM picks it up
    mem_en = 1'b0;
    do_store(64'h2000, 64'h0000_0000_AAAA_AAAA, 8'h0F, 1'b0, 1, g);
    check("coalesce_gnt_a", 64'(g), 64'd1);
    do_store(64'h2004, 64'hBBBB_BBBB_0000_0000, 8'hF0, 1'b0, 1, g);
    check("coalesce_gnt_b", 64'(g), 64'd1);
    exp_q.push_back('{64'h2000, 64'hBBBB_BBBB_AAAA_AAAA, 8'hFF});
    mem_en = 1'b1;
    wait_idle("coalesce_drain", 40);

    // Full queue: new word blocked, tail-word merge accepted
    mem_en = 1'b0;
    do_store(64'h4000, 64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1, g);
    check("full_fill0", 64'(g), 64'd1);
    do_store(64'h4008, 64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1, g);
    check("full_fill1", 64'(g), 64'd1);
    do_store(64'h4010, 64'h3333_3333_3333_3333, 8'hFF, 1'b0, 1, g);
    check("full_fill2", 64'(g), 64'd1);
    do_store(64'h4018, 64'h0000_0000_1818_1818, 8'h0F, 1'b0, 1, g);
    check("full_fill3", 64'(g), 64'd1);
    do_store(64'h4020, 64'h4444_4444_4444_4444, 8'hFF, 1'b0, 5, g);
    check("full_blocks_new_word", 64'(g), 64'd0);
    do_store(64'h401C, 64'h2424_2424_0000_0000, 8'hF0, 1'b0, 1, g);
    check("full_merge_granted", 64'(g), 64'd1);
    exp_q.push_back('{64'h4000, 64'h1111_1111_1111_1111, 8'hFF});
    exp_q.push_back('{64'h4008, 64'h2222_2222_2222_2222, 8'hFF});
    exp_q.push_back('{64'h4010, 64'h3333_3333_3333_3333, 8'hFF});
    exp_q.push_back('{64'h4018, 64'h2424_2424_1818_1818, 8'hFF});
    exp_q.push_back('{64'h4020, 64'h4444_4444_4444_4444, 8'hFF});
    mem_en = 1'b1;
    do_store(64'h4020, 64'h4444_4444_4444_4444, 8'hFF, 1'b0, 30, g);
    check("full_gnt_after_pop", 64'(g), 64'd1);
    wait_idle("full_drain", 100);

    // Reset while the head waits for its ack, then a stray ack
    gnt_only = 1'b1;
    exp_q.push_back('{64'h5000, 64'h5050_5050_5050_5050, 8'hFF});
    do_store(64'h5000, 64'h5050_5050_5050_5050, 8'hFF, 1'b0, 1, g);
    do_store(64'h5008, 64'h5858_5858_5858_5858, 8'hFF, 1'b0, 1, g);
    do_store(64'h5010, 64'h6060_6060_6060_6060, 8'hFF, 1'b0, 1, g);
    repeat (3) @(posedge clk_i);
    #1;
    check("wait_mem_req_low", 64'(mem_req_o), 64'd0);
    check("wait_not_idle", 64'(idle_o), 64'd0);
    check("wait_head_issued", 64'(exp_q.size()), 64'd0);
    gnt_only = 1'b0;
    rst_i    = 1'b1;
    @(posedge clk_i); #1;
    rst_i    = 1'b0;
    check("midwait_rst_idle", 64'(idle_o), 64'd1);
    check("midwait_rst_mem_req", 64'(mem_req_o), 64'd0);
    late_ack = 1'b1;
    @(posedge clk_i); #1;
    late_ack = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("late_ack_idle", 64'(idle_o), 64'd1);
    check("late_ack_mem_req", 64'(mem_req_o), 64'd0);
    exp_q.push_back('{64'h6000, 64'h0606_0606_0606_0606, 8'hFF});
    do_store(64'h6000, 64'h0606_0606_0606_0606, 8'hFF, 1'b0, 1, g);
    check("post_reset_gnt", 64'(g), 64'd1);
    wait_idle("post_reset_drain", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
